// File: rtl/sram_sp_wb_arb.sv
// Round-robin arbiter that shares one single-port SRAM between two Wishbone classic masters.
// Each transfer takes IDLE -> ACCESS -> RESP, three cycles. Out-of-range words answer with err.
module sram_sp_wb_arb #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_SIZE = 32768,
    localparam int SW      = DW / 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb0_cyc_i,
    input  logic          wb0_stb_i,
    input  logic          wb0_we_i,
    input  logic [AW-1:0] wb0_adr_i,
    input  logic [DW-1:0] wb0_dat_i,
    input  logic [SW-1:0] wb0_sel_i,
    output logic [DW-1:0] wb0_dat_o,
    output logic          wb0_ack_o,
    output logic          wb0_err_o,
    input  logic          wb1_cyc_i,
    input  logic          wb1_stb_i,
    input  logic          wb1_we_i,
    input  logic [AW-1:0] wb1_adr_i,
    input  logic [DW-1:0] wb1_dat_i,
    input  logic [SW-1:0] wb1_sel_i,
    output logic [DW-1:0] wb1_dat_o,
    output logic          wb1_ack_o,
    output logic          wb1_err_o,
    output logic          sram_ce,
    output logic          sram_we,
    output logic          sram_oe,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    output logic [SW-1:0] sram_sel,
    input  logic [DW-1:0] sram_dout,
    output logic [1:0]    dbg_state
);

    localparam int SHIFT = $clog2(SW);
    localparam int unsigned MEM_SIZE_WORDS = MEM_SIZE / SW;
    localparam logic [AW:0] WORD_LIMIT = (AW+1)'(MEM_SIZE_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic g, g_nxt, last, last_nxt, err_q, err_nxt;

    // Handshake: a master requests with cyc&stb and holds adr/we/dat/sel until it sees
    // a single-cycle ack or err; dropping the request before RESP abandons the transfer.
    logic req0, req1, req_g;
    logic g_we;
    logic [AW-1:0] g_adr, word;
    logic [DW-1:0] g_dat;
    logic [SW-1:0] g_sel;
    logic oor;
    logic resp_ack, resp_err;
    logic [DW-1:0] resp_dat;

    assign req0  = wb0_cyc_i & wb0_stb_i;
    assign req1  = wb1_cyc_i & wb1_stb_i;
    assign req_g = g ? req1 : req0;
    assign g_we  = g ? wb1_we_i  : wb0_we_i;
    assign g_adr = g ? wb1_adr_i : wb0_adr_i;
    assign g_dat = g ? wb1_dat_i : wb0_dat_i;
    assign g_sel = g ? wb1_sel_i : wb0_sel_i;
    assign word  = g_adr >> SHIFT;
    assign oor   = {1'b0, word} >= WORD_LIMIT;

    assign dbg_state = rst ? 2'd0 : state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            g     <= 1'b0;
            last  <= 1'b1;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            last  <= last_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        last_nxt  = last;
        err_nxt   = err_q;
        sram_ce   = 1'b0;
        sram_we   = 1'b0;
        sram_oe   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        sram_sel  = '0;
        resp_ack  = 1'b0;
        resp_err  = 1'b0;
        resp_dat  = '0;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    // On a tie the port that did not win last time goes first.
                    g_nxt     = (req0 & req1) ? ~last : req1;
                    last_nxt  = g_nxt;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!req_g) begin
                    state_nxt = IDLE;
                end else begin
                    err_nxt   = oor;
                    state_nxt = RESP;
                    if (!oor) begin
                        sram_ce   = 1'b1;
                        sram_we   = g_we;
                        sram_addr = word;
                        sram_din  = g_dat;
                        sram_sel  = g_sel;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
                if (req_g) begin
                    if (err_q) begin
                        resp_err = 1'b1;
                    end else begin
                        resp_ack = 1'b1;
                        if (!g_we) begin
                            sram_oe  = 1'b1;
                            resp_dat = sram_dout;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs stay quiet while reset is held, even mid-transfer.
        if (rst) begin
            sram_ce   = 1'b0;
            sram_we   = 1'b0;
            sram_oe   = 1'b0;
            sram_addr = '0;
            sram_din  = '0;
            sram_sel  = '0;
            resp_ack  = 1'b0;
            resp_err  = 1'b0;
            resp_dat  = '0;
        end
        wb0_ack_o = resp_ack & ~g;
        wb1_ack_o = resp_ack & g;
        wb0_err_o = resp_err & ~g;
        wb1_err_o = resp_err & g;
        wb0_dat_o = g ? '0 : resp_dat;
        wb1_dat_o = g ? resp_dat : '0;
    end

endmodule

// File: tb/tb_sram_sp_wb_arb.sv
// Bench for sram_sp_wb_arb: directed transfers with literal expectations, plus a
// transfer-level reference model compared against every output on every cycle.
module tb_sram_sp_wb_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wb0_cyc_i = 0, wb0_stb_i = 0, wb0_we_i = 0;
  logic [31:0] wb0_adr_i = 0, wb0_dat_i = 0;
  logic [3:0] wb0_sel_i = 0;
  logic wb1_cyc_i = 0, wb1_stb_i = 0, wb1_we_i = 0;
  logic [31:0] wb1_adr_i = 0, wb1_dat_i = 0;
  logic [3:0] wb1_sel_i = 0;
  logic [31:0] wb0_dat_o, wb1_dat_o;
  logic wb0_ack_o, wb0_err_o, wb1_ack_o, wb1_err_o;
  logic sram_ce, sram_we, sram_oe;
  logic [31:0] sram_addr, sram_din;
  logic [3:0] sram_sel;
  logic [31:0] sram_dout = 0;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  sram_sp_wb_arb #(.AW(32), .DW(32), .MEM_SIZE(1024)) dut (
    .clk(clk), .rst(rst),
    .wb0_cyc_i(wb0_cyc_i), .wb0_stb_i(wb0_stb_i), .wb0_we_i(wb0_we_i),
    .wb0_adr_i(wb0_adr_i), .wb0_dat_i(wb0_dat_i), .wb0_sel_i(wb0_sel_i),
    .wb0_dat_o(wb0_dat_o), .wb0_ack_o(wb0_ack_o), .wb0_err_o(wb0_err_o),
    .wb1_cyc_i(wb1_cyc_i), .wb1_stb_i(wb1_stb_i), .wb1_we_i(wb1_we_i),
    .wb1_adr_i(wb1_adr_i), .wb1_dat_i(wb1_dat_i), .wb1_sel_i(wb1_sel_i),
    .wb1_dat_o(wb1_dat_o), .wb1_ack_o(wb1_ack_o), .wb1_err_o(wb1_err_o),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_sel(sram_sel),
    .sram_dout(sram_dout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // SRAM stand-in: 256 words, registered read, byte-masked write
  logic [31:0] sram_mem [0:255];
  initial for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0;
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_sel[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr[7:0]];
      end
    end
  end

  function automatic logic [138:0] outs();
    return {wb0_dat_o, wb0_ack_o, wb0_err_o, wb1_dat_o, wb1_ack_o, wb1_err_o,
            sram_ce, sram_we, sram_oe, sram_addr, sram_din, sram_sel};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_wide(input string name, input logic [138:0] act, input logic [138:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // reference model: one transfer = grant, access, response; memory as a word array
  logic [31:0] ref_mem [0:255];
  initial for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
  int ph = 0;
  int mg = 0;
  bit mlast = 1'b1;
  bit moor = 1'b0;
  logic [31:0] mword = 0;
  int cyc_n = 0;

  always @(negedge clk) begin
    logic [1:0] req;
    logic [31:0] e_dat [2];
    logic e_ack [2];
    logic e_err [2];
    logic e_ce, e_we, e_oe;
    logic [31:0] e_addr, e_din, adr, dat;
    logic [3:0] e_sel, sel;
    logic we;
    req = {wb1_cyc_i & wb1_stb_i, wb0_cyc_i & wb0_stb_i};
    e_dat[0] = 0; e_dat[1] = 0; e_ack[0] = 0; e_ack[1] = 0; e_err[0] = 0; e_err[1] = 0;
    e_ce = 0; e_we = 0; e_oe = 0; e_addr = 0; e_din = 0; e_sel = 0;
    adr = (mg == 1) ? wb1_adr_i : wb0_adr_i;
    dat = (mg == 1) ? wb1_dat_i : wb0_dat_i;
    sel = (mg == 1) ? wb1_sel_i : wb0_sel_i;
    we  = (mg == 1) ? wb1_we_i  : wb0_we_i;
    if (rst) begin
      ph = 0;
      mlast = 1'b1;
    end else if (ph == 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) mg = mlast ? 0 : 1;
        else mg = req[1] ? 1 : 0;
        mlast = (mg == 1);
        ph = 1;
      end
    end else if (ph == 1) begin
      if (!req[mg]) begin
        ph = 0;
      end else begin
        mword = adr / 4;
        moor = (mword >= 256);
        if (!moor) begin
          e_ce = 1; e_we = we; e_addr = mword; e_din = dat; e_sel = sel;
          if (we)
            for (int b = 0; b < 4; b++)
              if (sel[b]) ref_mem[mword[7:0]][8*b +: 8] = dat[8*b +: 8];
        end
        ph = 2;
      end
    end else begin
      if (req[mg]) begin
        if (moor) e_err[mg] = 1;
        else begin
          e_ack[mg] = 1;
          if (!we) begin
            e_oe = 1;
            e_dat[mg] = ref_mem[mword[7:0]];
          end
        end
      end
      ph = 0;
    end
    chk_wide($sformatf("cycle_outputs@%0d", cyc_n), outs(),
             {e_dat[0], e_ack[0], e_err[0], e_dat[1], e_ack[1], e_err[1],
              e_ce, e_we, e_oe, e_addr, e_din, e_sel});
    cyc_n++;
  end

  // driver tasks
  task automatic drive(input int p, input bit req, input bit we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    if (p == 0) begin
      wb0_cyc_i = req; wb0_stb_i = req; wb0_we_i = we;
      wb0_adr_i = adr; wb0_dat_i = dat; wb0_sel_i = sel;
    end else begin
      wb1_cyc_i = req; wb1_stb_i = req; wb1_we_i = we;
      wb1_adr_i = adr; wb1_dat_i = dat; wb1_sel_i = sel;
    end
  endtask

  task automatic xfer(input int p, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat, output bit ack,
                      output bit err, output int lat, output logic [31:0] acc_addr,
                      output bit acc_we, output bit acc_ce);
    @(posedge clk); #1;
    drive(p, 1, we, adr, dat, sel);
    lat = 0; ack = 0; err = 0; rdat = 0; acc_addr = 0; acc_we = 0; acc_ce = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        acc_addr = sram_addr; acc_we = sram_we; acc_ce = sram_ce;
      end
      if ((p == 0) ? (wb0_ack_o | wb0_err_o) : (wb1_ack_o | wb1_err_o)) begin
        ack  = (p == 0) ? wb0_ack_o : wb1_ack_o;
        err  = (p == 0) ? wb0_err_o : wb1_err_o;
        rdat = (p == 0) ? wb0_dat_o : wb1_dat_o;
        break;
      end
      if (lat >= 20) begin
        checks++; failures++;
        $display("FAIL xfer_timeout port=%0d actual=no_response required=response", p);
        break;
      end
    end
    @(posedge clk); #1;
    drive(p, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] rdat, acc_addr;
    bit ack, err, acc_we, acc_ce;
    int lat, n_ack;

    repeat (3) @(negedge clk);
    chk_wide("reset_outputs", outs(), '0);
    @(posedge clk); #1 rst = 0;

    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    chk("wr_ack", ack, 1); chk("wr_lat", lat, 3);
    chk("wr_sram_addr", acc_addr, 4); chk("wr_sram_we", acc_we, 1);
    xfer(0, 0, 32'h10, 0, 4'hF, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    chk("rd_data", rdat, 32'hDEADBEEF); chk("rd_ack", ack, 1);

    xfer(0, 1, 32'h10, 32'h00AA0000, 4'b0100, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    xfer(0, 0, 32'h10, 0, 4'hF, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    chk("byte_wr_data", rdat, 32'hDEAABEEF);

    xfer(1, 1, 32'h0, 32'h11223344, 4'hF, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    xfer(1, 0, 32'h3FC, 0, 4'hF, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    chk("last_word_ack", ack, 1); chk("last_word_err", err, 0);
    xfer(1, 0, 32'h400, 0, 4'hF, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    chk("oor_rd_err", err, 1); chk("oor_rd_ack", ack, 0);
    chk("oor_rd_ce", acc_ce, 0); chk("oor_rd_lat", lat, 3);
    xfer(1, 1, 32'h400, 32'hFFFFFFFF, 4'hF, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    chk("oor_wr_err", err, 1);
    xfer(1, 0, 32'h0, 0, 4'hF, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    chk("oor_wr_no_change", rdat, 32'h11223344);

    // both ports held requesting: grants must alternate starting at port 0
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h10, 0, 4'hF);
    drive(1, 1, 0, 32'h0, 0, 4'hF);
    for (int k = 0; k < 4; k++) exp_q.push_back(k % 2);
    n_ack = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (wb0_ack_o | wb1_ack_o) begin
        chk("tie_single_ack", wb0_ack_o & wb1_ack_o, 0);
        if (exp_q.size() > 0) chk("tie_port", wb1_ack_o, exp_q.pop_front());
        chk("tie_cycle", c, 2 + 3 * n_ack);
        n_ack++;
      end
    end
    chk("tie_count", n_ack, 4);
    exp_q.delete();
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // port 0 abandons its write in ACCESS, pending port 1 takes the next slot
    @(posedge clk); #1;
    drive(0, 1, 1, 32'h20, 32'h55555555, 4'hF);
    @(negedge clk);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 32'h10, 0, 4'hF);
    @(negedge clk);
    chk("drop_sram_we", sram_we, 0); chk("drop_sram_ce", sram_ce, 0);
    @(negedge clk);
    chk("drop_state_idle", dbg_state, 0);
    lat = 2;
    while (!wb1_ack_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("drop_p1_lat", lat, 4); chk("drop_p1_data", wb1_dat_o, 32'hDEAABEEF);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0);
    xfer(0, 0, 32'h20, 0, 4'hF, rdat, ack, err, lat, acc_addr, acc_we, acc_ce);
    chk("drop_no_write", rdat, 32'h0);

    // reset lands in the RESP cycle of a read
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h10, 0, 4'hF);
    @(posedge clk);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    chk("rst_resp_ack", wb0_ack_o, 0); chk_wide("rst_resp_outputs", outs(), '0);
    @(posedge clk); #1 rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_state_idle", dbg_state, 0);
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h10, 0, 4'hF);
    drive(1, 1, 0, 32'h0, 0, 4'hF);
    n_ack = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) chk("post_rst_tie_p0", {wb0_ack_o, wb1_ack_o}, 2'b10);
      if (c == 5) chk("post_rst_tie_p1", {wb0_ack_o, wb1_ack_o}, 2'b01);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
